// File: rtl/video_timing_decoder.sv
// video_timing_decoder
//   Recovers pixel coordinates from a VDE/VSync video stream, measures the active
//   line width and frame height, and locks once LOCK_FRAMES consecutive frames match
//   H_ACTIVE x V_ACTIVE. HSync is accepted but ignored; VDE and VSync define geometry.
//
//   Optional feature: define VIDEO_TIMING_DECODER_CRC_EN to accumulate a CRC-16-CCITT
//   (poly 0x1021, init 0xFFFF, MSB first) over each frame's 24-bit pixels.
//
// Ports
//   clk, rst (async, active-high)
//   RGB_VDE, RGB_HSync, RGB_VSync, RGB_Data[23:0]  video input
//   pix_valid, pix_data, pix_x, pix_y              pixel stream, 1-cycle latency
//   frame_start                                    pulse after a VSync rising edge
//   h_active_meas, v_active_meas                   last measured width / height
//   locked, err_count                              lock status, saturating lock losses
//   frame_crc                                      CRC of last frame (0 without macro)
module video_timing_decoder #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RGB_VDE,
  input  logic        RGB_HSync,
  input  logic        RGB_VSync,
  input  logic [23:0] RGB_Data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        frame_start,
  output logic [11:0] h_active_meas,
  output logic [11:0] v_active_meas,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [11:0] HActiveW = 12'(H_ACTIVE);
  localparam logic [11:0] VActiveW = 12'(V_ACTIVE);
  localparam logic [3:0]  LockW    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StUnlocked, StCheck, StLocked} state_e;

  logic        vde_q, vsync_q;
  logic [11:0] hcnt_q;   // VDE-high cycles in the current line
  logic [11:0] line_q;   // lines completed since the last VSync edge
  logic        bad_q;    // sticky: some line in this frame had the wrong width
  logic        armed_q;  // a VSync edge has been seen since reset
  state_e      state_q;
  logic [3:0]  good_cnt_q;

  logic        vde_fall, vs_rise, line_bad, bad_frame, frame_good, judge;
  logic [11:0] hcnt_inc, line_inc, lines_frame;

  // HSync plays no part in geometry recovery.
  logic unused_hsync;
  assign unused_hsync = RGB_HSync;

  always_comb begin
    vde_fall    = vde_q & ~RGB_VDE;
    vs_rise     = RGB_VSync & ~vsync_q;
    hcnt_inc    = (hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1;
    line_inc    = (line_q == 12'hFFF) ? line_q : line_q + 12'd1;
    line_bad    = (hcnt_q != HActiveW);
    // A line ending in the same cycle as VSync rises still belongs to the outgoing frame.
    lines_frame = vde_fall ? line_inc : line_q;
    bad_frame   = bad_q | (vde_fall & line_bad);
    frame_good  = ~bad_frame & (lines_frame == VActiveW);
    judge       = vs_rise & armed_q;
  end

  // Pixel path, geometry measurement and frame bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vde_q         <= 1'b0;
      vsync_q       <= 1'b0;
      hcnt_q        <= '0;
      line_q        <= '0;
      bad_q         <= 1'b0;
      armed_q       <= 1'b0;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      frame_start   <= 1'b0;
      h_active_meas <= '0;
      v_active_meas <= '0;
    end else begin
      vde_q       <= RGB_VDE;
      vsync_q     <= RGB_VSync;
      pix_valid   <= RGB_VDE;
      pix_data    <= RGB_Data;
      frame_start <= vs_rise;
      if (RGB_VDE) begin
        pix_x  <= hcnt_q;
        pix_y  <= line_q;
        hcnt_q <= hcnt_inc;
      end
      if (vde_fall) begin
        h_active_meas <= hcnt_q;
        hcnt_q        <= '0;
        line_q        <= line_inc;
        if (line_bad) bad_q <= 1'b1;
      end
      // Frame boundary overrides the line-end updates above.
      if (vs_rise) begin
        v_active_meas <= lines_frame;
        line_q        <= '0;
        bad_q         <= 1'b0;
        armed_q       <= 1'b1;
      end
    end
  end

  // Lock FSM; evaluated once per judged frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StUnlocked;
      good_cnt_q <= '0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else if (judge) begin
      unique case (state_q)
        StUnlocked: begin
          if (frame_good) begin
            good_cnt_q <= 4'd1;
            if (LockW <= 4'd1) begin
              state_q <= StLocked;
              locked  <= 1'b1;
            end else begin
              state_q <= StCheck;
            end
          end
        end
        StCheck: begin
          if (frame_good) begin
            good_cnt_q <= good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 >= LockW) begin
              state_q <= StLocked;
              locked  <= 1'b1;
            end
          end else begin
            state_q    <= StUnlocked;
            good_cnt_q <= '0;
          end
        end
        StLocked: begin
          if (!frame_good) begin
            state_q    <= StUnlocked;
            good_cnt_q <= '0;
            locked     <= 1'b0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: begin
          state_q    <= StUnlocked;
          good_cnt_q <= '0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

`ifdef VIDEO_TIMING_DECODER_CRC_EN
  logic [15:0] crc_q, crc_upd;

  // CRC-16-CCITT over one 24-bit word, MSB first.
  function automatic logic [15:0] crc16_w24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 23; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  assign crc_upd = RGB_VDE ? crc16_w24(crc_q, RGB_Data) : crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= '0;
      frame_crc <= '0;
    end else if (vs_rise) begin
      frame_crc <= crc_upd;
      crc_q     <= 16'hFFFF;
    end else begin
      crc_q <= crc_upd;
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_video_timing_decoder.sv
// Bench for video_timing_decoder at a reduced 8x6 geometry, LOCK_FRAMES=2.
// A frame-level model (pixel/line indices, run of good frames) predicts every
// output; a negedge process compares, and directed literal checks pin the model.
module tb_video_timing_decoder;
  localparam int H = 8;
  localparam int V = 6;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        RGB_VDE, RGB_HSync, RGB_VSync;
  logic [23:0] RGB_Data;
  logic [11:0] pix_x, pix_y, h_active_meas, v_active_meas;
  logic        pix_valid, frame_start, locked;
  logic [23:0] pix_data;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  video_timing_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(L)) dut (
    .clk(clk), .rst(rst), .RGB_VDE(RGB_VDE), .RGB_HSync(RGB_HSync), .RGB_VSync(RGB_VSync),
    .RGB_Data(RGB_Data), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_start(frame_start), .h_active_meas(h_active_meas),
    .v_active_meas(v_active_meas), .locked(locked), .err_count(err_count),
    .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model state
  int          m_px, m_ln, m_run, m_err, m_h, m_v;
  bit          m_bad, m_armed, m_pvde, m_pvs;
  logic [15:0] m_crc, m_fcrc;

  // Expected outputs for the coming edge (nxt_*) and for the current cycle (exp_*)
  logic        nxt_valid, nxt_fs, nxt_locked, exp_valid, exp_fs, exp_locked;
  logic [23:0] nxt_data, exp_data;
  logic [11:0] nxt_x, nxt_y, nxt_h, nxt_v, exp_x, exp_y, exp_h, exp_v;
  logic [7:0]  nxt_err, exp_err;
  logic [15:0] nxt_crc, exp_crc;

  int          data_mode = 0;
  logic [23:0] vec [3];

  function automatic logic [15:0] crc_w(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 23; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [11:0] sat12(input int v);
    return (v > 4095) ? 12'hFFF : 12'(v);
  endfunction

  always @(posedge clk) begin
    exp_valid  <= nxt_valid;
    exp_data   <= nxt_data;
    exp_x      <= nxt_x;
    exp_y      <= nxt_y;
    exp_fs     <= nxt_fs;
    exp_h      <= nxt_h;
    exp_v      <= nxt_v;
    exp_locked <= nxt_locked;
    exp_err    <= nxt_err;
    exp_crc    <= nxt_crc;
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("pix_valid", 32'(pix_valid), 32'(exp_valid));
      chk("pix_data", 32'(pix_data), 32'(exp_data));
      if (exp_valid) begin
        chk("pix_x", 32'(pix_x), 32'(exp_x));
        chk("pix_y", 32'(pix_y), 32'(exp_y));
      end
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      chk("h_active_meas", 32'(h_active_meas), 32'(exp_h));
      chk("v_active_meas", 32'(v_active_meas), 32'(exp_v));
      chk("locked", 32'(locked), 32'(exp_locked));
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("frame_crc", 32'(frame_crc), 32'(exp_crc));
    end
  end

  task automatic model_clear();
    m_px = 0; m_ln = 0; m_run = 0; m_err = 0; m_h = 0; m_v = 0;
    m_bad = 0; m_armed = 0; m_pvde = 0; m_pvs = 0; m_crc = '0; m_fcrc = '0;
    nxt_valid = 0; nxt_data = '0; nxt_x = '0; nxt_y = '0; nxt_fs = 0;
    nxt_h = '0; nxt_v = '0; nxt_locked = 0; nxt_err = '0; nxt_crc = '0;
  endtask

  // One input cycle plus the model's view of what it means.
  task automatic drive(input logic vde, input logic vs, input logic hs, input logic [23:0] d);
    bit fall, rise, good;
    @(posedge clk);
    #2;
    RGB_VDE = vde; RGB_VSync = vs; RGB_HSync = hs; RGB_Data = d;
    fall = m_pvde && !vde;
    rise = vs && !m_pvs;
    nxt_valid = vde;
    nxt_data  = d;
    if (vde) begin
      nxt_x = sat12(m_px);
      nxt_y = sat12(m_ln);
      m_px++;
      m_crc = crc_w(m_crc, d);
    end
    if (fall) begin
      m_h = m_px;
      if (m_px != H) m_bad = 1;
      m_ln++;
      m_px = 0;
    end
    if (rise) begin
      m_v = m_ln;
      if (m_armed) begin
        good = !m_bad && (m_ln == V);
        if (good) m_run++;
        else begin
          if (m_run >= L && m_err < 255) m_err++;
          m_run = 0;
        end
      end
      m_armed = 1;
      m_ln = 0;
      m_bad = 0;
      m_fcrc = m_crc;
      m_crc = 16'hFFFF;
    end
    nxt_fs     = rise;
    nxt_h      = sat12(m_h);
    nxt_v      = sat12(m_v);
    nxt_locked = (m_run >= L);
    nxt_err    = 8'(m_err);
`ifdef VIDEO_TIMING_DECODER_CRC_EN
    nxt_crc    = m_fcrc;
`else
    nxt_crc    = '0;
`endif
    m_pvde = vde;
    m_pvs  = vs;
  endtask

  function automatic logic [23:0] pixel(input int l, input int i);
    if (data_mode == 1) return 24'h000000;
    if (data_mode == 2) return vec[i % 3];
    return {8'(l * 17 + 3), 8'(i), 8'h5A};
  endfunction

  task automatic send_line(input int l, input int w, input bit blank);
    for (int i = 0; i < w; i++) drive(1'b1, 1'b0, 1'b0, pixel(l, i));
    if (blank) for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, (k == 1), 24'h0);
  endtask

  task automatic vsync_pulse();
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // Lines, then the VSync edge that closes the frame. coinc puts the last line's
  // VDE fall in the same cycle as the VSync rise.
  task automatic send_frame(input int nlines, input int bad_idx, input int bad_w,
                            input bit coinc);
    for (int l = 0; l < nlines; l++)
      send_line(l, (l == bad_idx) ? bad_w : H, !(coinc && l == nlines - 1));
    vsync_pulse();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RGB_VDE = 0; RGB_VSync = 0; RGB_HSync = 0; RGB_Data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst pix_valid", 32'(pix_valid), 32'd0);
    chk("rst pix_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("rst pix_data", 32'(pix_data), 32'd0);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    chk("rst meas", 32'({h_active_meas, v_active_meas}), 32'd0);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst frame_crc", 32'(frame_crc), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    RGB_VDE = 0; RGB_VSync = 0; RGB_HSync = 0; RGB_Data = '0;
    vec[0] = 24'h313233; vec[1] = 24'h343536; vec[2] = 24'h373839;
    model_clear();
    do_reset();
    chk_en = 1'b1;

    // Arm, then two clean frames lock.
    vsync_pulse();
    send_frame(V, -1, 0, 0);
    chk("lock after 1 good", 32'(locked), 32'd0);
    send_frame(V, -1, 0, 0);
    chk("lock after 2 good", 32'(locked), 32'd1);
    chk("h_meas clean", 32'(h_active_meas), 32'd8);
    chk("v_meas clean", 32'(v_active_meas), 32'd6);

    // Short line drops lock; two clean frames relock.
    send_frame(V, 3, H - 1, 0);
    chk("unlock short line", 32'(locked), 32'd0);
    chk("err after short", 32'(err_count), 32'd1);
    send_frame(V, -1, 0, 0);
    chk("relock 1", 32'(locked), 32'd0);
    send_frame(V, -1, 0, 0);
    chk("relock 2", 32'(locked), 32'd1);

    // Too few lines.
    send_frame(V - 1, -1, 0, 0);
    chk("v_meas short frame", 32'(v_active_meas), 32'd5);
    chk("unlock short frame", 32'(locked), 32'd0);
    chk("err after short frame", 32'(err_count), 32'd2);
    send_frame(V, -1, 0, 0);
    chk("no lock from one good", 32'(locked), 32'd0);

    // Coincident VDE fall / VSync rise on the last line counts that line.
    send_frame(V, -1, 0, 1);
    chk("coinc judged good", 32'(locked), 32'd1);
    chk("coinc v_meas", 32'(v_active_meas), 32'd6);
    chk("coinc last pix_y", 32'(pix_y), 32'd5);

    // Reset mid-frame; the partial frame after reset only arms.
    for (int l = 0; l < 3; l++) send_line(l, H, 1'b1);
    send_line(3, 4, 1'b0);
    do_reset();
    send_frame(2, -1, 0, 0);
    chk("partial v_meas", 32'(v_active_meas), 32'd2);
    chk("partial not judged", 32'(locked), 32'd0);
    send_frame(V, -1, 0, 0);
    chk("post-rst lock 2", 32'(locked), 32'd0);
    send_frame(V, -1, 0, 0);
    chk("post-rst lock 3", 32'(locked), 32'd1);
    chk("post-rst err", 32'(err_count), 32'd0);

    // CRC: known vector "123456789", then an all-zero frame.
    data_mode = 2;
    send_frame(1, 0, 3, 0);
`ifdef VIDEO_TIMING_DECODER_CRC_EN
    chk("crc 123456789", 32'(frame_crc), 32'h29B1);
`else
    chk("crc disabled", 32'(frame_crc), 32'd0);
`endif
    data_mode = 1;
    send_frame(V, -1, 0, 0);
    data_mode = 0;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
